// File: rtl/bus_mem_if.sv
// bus_mem_if: CPU bus request/done handshake between an initiator (master) and a memory responder (slave)
//   read_q/write_q/addr_in/data_in/halt_q : initiator -> responder
//   data_out/read_dn/write_dn/bus_busy/rw_halt/err : responder -> initiator
interface bus_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              read_dn;
  logic              write_dn;
  logic              bus_busy;
  logic              halt_q;
  logic              rw_halt;
  logic              err;
  modport master (
    output read_q, write_q, addr_in, data_in, halt_q,
    input  data_out, read_dn, write_dn, bus_busy, rw_halt, err
  );
  modport slave (
    input  read_q, write_q, addr_in, data_in, halt_q,
    output data_out, read_dn, write_dn, bus_busy, rw_halt, err
  );
endinterface

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: word-addressed RAM servicing read/write requests with programmable wait states and bus halt
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : bus_mem_if slave side (requests in; done flags, read data, busy, halt grant, error pulse out)
module bus_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_AW  = 10,
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 1
) (
  input logic     clk,
  input logic     rst,
  bus_mem_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE, HALT} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic              oor;
  assign oor = |(addr_r >> MEM_AW);
  // RAM has no reset; a write commits only on its done edge, so a reset that
  // forces state to IDLE beforehand cancels it.
  always_ff @(posedge clk)
    if (state == WR_WAIT && cnt == '0 && !oor) mem[addr_r[MEM_AW-1:0]] <= data_r;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_r       <= '0;
      data_r       <= '0;
      bus.data_out <= '0;
      bus.read_dn  <= 1'b0;
      bus.write_dn <= 1'b0;
      bus.bus_busy <= 1'b0;
      bus.rw_halt  <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE:
          if (bus.halt_q) begin
            state        <= HALT;
            bus.rw_halt  <= 1'b1;
            bus.bus_busy <= 1'b1;
          end else if (bus.read_q && bus.write_q) bus.err <= 1'b1;
          else if (bus.read_q) begin
            state        <= RD_WAIT;
            addr_r       <= bus.addr_in;
            cnt          <= 4'(WAIT_RD);
            bus.bus_busy <= 1'b1;
          end else if (bus.write_q) begin
            state        <= WR_WAIT;
            addr_r       <= bus.addr_in;
            data_r       <= bus.data_in;
            cnt          <= 4'(WAIT_WR);
            bus.bus_busy <= 1'b1;
          end
        RD_WAIT:
          if (cnt == '0) begin
            state        <= RD_DONE;
            bus.read_dn  <= 1'b1;
            bus.data_out <= oor ? '0 : mem[addr_r[MEM_AW-1:0]];
            bus.err      <= oor;
          end else cnt <= cnt - 4'd1;
        WR_WAIT:
          if (cnt == '0) begin
            state        <= WR_DONE;
            bus.write_dn <= 1'b1;
            bus.err      <= oor;
          end else cnt <= cnt - 4'd1;
        RD_DONE:
          if (!bus.read_q) begin
            state        <= IDLE;
            bus.read_dn  <= 1'b0;
            bus.data_out <= '0;
            bus.bus_busy <= 1'b0;
          end
        WR_DONE:
          if (!bus.write_q) begin
            state        <= IDLE;
            bus.write_dn <= 1'b0;
            bus.bus_busy <= 1'b0;
          end
        HALT:
          if (!bus.halt_q) begin
            state        <= IDLE;
            bus.rw_halt  <= 1'b0;
            bus.bus_busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed self-checking bench for bus_mem_responder
module tb_bus_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  logic [31:0] rd;
  logic        e;
  bus_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10), .WAIT_RD(2), .WAIT_WR(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic err_seen);
    bit done = 0;
    bus.addr_in = a;
    bus.data_in = d;
    bus.write_q = 1'b1;
    err_seen = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = bus.write_dn;
      err_seen = bus.err;
    end
    if (!done) chk("write_timeout", 0, 1);
    bus.write_q = 1'b0;
    tick();
  endtask
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic err_seen);
    bit done = 0;
    bus.addr_in = a;
    bus.read_q = 1'b1;
    d = '0;
    err_seen = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = bus.read_dn;
      d = bus.data_out;
      err_seen = bus.err;
    end
    if (!done) chk("read_timeout", 0, 1);
    bus.read_q = 1'b0;
    tick();
  endtask
  initial begin
    bus.read_q = 0;
    bus.write_q = 0;
    bus.halt_q = 0;
    bus.addr_in = 0;
    bus.data_in = 0;
    tick(2);
    chk("rst_outs", {bus.read_dn, bus.write_dn, bus.bus_busy, bus.rw_halt, bus.err}, 0);
    chk("rst_data", bus.data_out, 0);
    rst = 1'b1;
    // write 0x5 = DEADBEEF, WAIT_WR=1: done two edges after acceptance
    bus.addr_in = 32'h5;
    bus.data_in = 32'hDEADBEEF;
    bus.write_q = 1'b1;
    tick();
    chk("wr_busy", bus.bus_busy, 1);
    bus.data_in = 32'h0BAD0BAD;
    bus.addr_in = 32'h9;
    tick();
    chk("wr_dn_early", bus.write_dn, 0);
    tick();
    chk("wr_dn", bus.write_dn, 1);
    chk("wr_err", bus.err, 0);
    tick();
    chk("wr_dn_hold", bus.write_dn, 1);
    bus.write_q = 1'b0;
    tick();
    chk("wr_release", {bus.write_dn, bus.bus_busy}, 0);
    // read 0x5, WAIT_RD=2: done three edges after acceptance
    bus.addr_in = 32'h5;
    bus.read_q = 1'b1;
    tick(3);
    chk("rd_dn_early", bus.read_dn, 0);
    chk("rd_data_early", bus.data_out, 0);
    tick();
    chk("rd_dn", bus.read_dn, 1);
    chk("rd_data", bus.data_out, 32'hDEADBEEF);
    bus.read_q = 1'b0;
    tick();
    chk("rd_release", {bus.read_dn, bus.bus_busy}, 0);
    chk("rd_data_zero", bus.data_out, 0);
    // simultaneous read and write request
    bus.addr_in = 32'h5;
    bus.data_in = 32'h0;
    bus.read_q = 1'b1;
    bus.write_q = 1'b1;
    tick();
    chk("both_err", bus.err, 1);
    chk("both_idle", {bus.read_dn, bus.write_dn, bus.bus_busy}, 0);
    bus.read_q = 1'b0;
    bus.write_q = 1'b0;
    tick();
    chk("both_err_pulse", bus.err, 0);
    do_read(32'h5, rd, e);
    chk("both_ram_kept", rd, 32'hDEADBEEF);
    // out-of-range accesses
    do_write(32'h0, 32'h12345678, e);
    chk("wr0_err", e, 0);
    do_write(32'h400, 32'hCAFEF00D, e);
    chk("oor_wr_err", e, 1);
    do_read(32'h0, rd, e);
    chk("oor_alias_data", rd, 32'h12345678);
    chk("oor_alias_err", e, 0);
    do_read(32'h400, rd, e);
    chk("oor_rd_data", rd, 0);
    chk("oor_rd_err", e, 1);
    // halt raised during RD_WAIT, write held off until halt released
    bus.addr_in = 32'h5;
    bus.read_q = 1'b1;
    tick();
    bus.halt_q = 1'b1;
    tick(2);
    chk("halt_rd_wait", {bus.read_dn, bus.rw_halt}, 0);
    tick();
    chk("halt_rd_dn", bus.read_dn, 1);
    chk("halt_rd_data", bus.data_out, 32'hDEADBEEF);
    bus.read_q = 1'b0;
    bus.addr_in = 32'h7;
    bus.data_in = 32'hA5A5A5A5;
    bus.write_q = 1'b1;
    tick();
    chk("halt_idle", {bus.read_dn, bus.bus_busy, bus.rw_halt}, 0);
    tick();
    chk("halt_grant", {bus.rw_halt, bus.bus_busy}, 2'b11);
    tick(2);
    chk("halt_hold", {bus.rw_halt, bus.write_dn}, 2'b10);
    bus.halt_q = 1'b0;
    tick();
    chk("halt_release", {bus.rw_halt, bus.bus_busy}, 0);
    tick();
    chk("halt_wr_accept", bus.bus_busy, 1);
    tick(2);
    chk("halt_wr_dn", bus.write_dn, 1);
    bus.write_q = 1'b0;
    tick();
    do_read(32'h7, rd, e);
    chk("halt_wr_data", rd, 32'hA5A5A5A5);
    // read dropped during wait: done lasts exactly one cycle
    bus.addr_in = 32'h0;
    bus.read_q = 1'b1;
    tick();
    bus.read_q = 1'b0;
    tick(3);
    chk("drop_dn", bus.read_dn, 1);
    chk("drop_data", bus.data_out, 32'h12345678);
    tick();
    chk("drop_dn_1cyc", {bus.read_dn, bus.bus_busy}, 0);
    // reset one cycle before write_dn rises: write aborted
    bus.addr_in = 32'h5;
    bus.data_in = 32'h11111111;
    bus.write_q = 1'b1;
    tick(2);
    chk("abort_pre", {bus.bus_busy, bus.write_dn}, 2'b10);
    rst = 1'b0;
    #1;
    chk("abort_async", bus.bus_busy, 0);
    bus.write_q = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    do_read(32'h5, rd, e);
    chk("abort_old_data", rd, 32'hDEADBEEF);
    // back-to-back reads: busy low for exactly one cycle
    bus.addr_in = 32'h7;
    bus.read_q = 1'b1;
    tick(4);
    chk("b2b_dn1", bus.read_dn, 1);
    bus.read_q = 1'b0;
    tick();
    chk("b2b_gap", {bus.read_dn, bus.bus_busy}, 0);
    bus.addr_in = 32'h0;
    bus.read_q = 1'b1;
    tick();
    chk("b2b_busy2", bus.bus_busy, 1);
    tick(3);
    chk("b2b_dn2", bus.read_dn, 1);
    chk("b2b_data2", bus.data_out, 32'h12345678);
    bus.read_q = 1'b0;
    tick();
    chk("b2b_end", {bus.read_dn, bus.bus_busy}, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
